// File: rtl/coin_payout_if.sv
// Coin payout bus: cash-out request and credit in, solenoid drives and status out.
// The game controller / bench side is master; the payout controller is slave.
interface coin_payout_if;
    logic        cash_btn;
    logic [11:0] credit;
    logic        exit_sense;
    logic        eject10;
    logic        eject5;
    logic        busy;
    logic        done;
    logic        jam;
    logic [11:0] remaining;

    modport master (
        output cash_btn, credit, exit_sense,
        input  eject10, eject5, busy, done, jam, remaining
    );

    modport slave (
        input  cash_btn, credit, exit_sense,
        output eject10, eject5, busy, done, jam, remaining
    );
endinterface

// File: rtl/coin_payout.sv
// Coin payout controller: latches a BCD credit on a cash-out edge, ejects
// 10-unit coins then at most one 5-unit coin, confirms each on the IR exit
// sensor, retries a silent attempt once and latches jam on a second failure.
module coin_payout #(
    parameter int PULSE_W = 5_000_000,
    parameter int TIMEOUT = 50_000_000,
    parameter int GAP     = 10_000_000
) (
    input  logic          clk,
    input  logic          rst,
    coin_payout_if.slave  bus
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FIRE       = 3'd1;
    localparam logic [2:0] S_WAIT_SENSE = 3'd2;
    localparam logic [2:0] S_WAIT_CLEAR = 3'd3;
    localparam logic [2:0] S_GAP        = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;
    localparam logic [2:0] S_JAM        = 3'd6;

    localparam logic [31:0] PULSE_LAST   = 32'(PULSE_W - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] GAP_LAST     = 32'(GAP - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        sel10_q, sel10_d;
    logic        retry_q, retry_d;
    logic [11:0] rem_q, rem_d;
    logic        e10_q, e10_d;
    logic        e5_q, e5_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        jam_q, jam_d;
    logic        sync1_q, sync2_q;
    logic        btn_q;
    logic        btn_rise;

    // A balance is payable while at least one whole coin is still owed.
    function automatic logic payable(input logic [11:0] b);
        return (b[11:8] != 4'd0) || (b[7:4] != 4'd0) || (b[3:0] >= 4'd5);
    endfunction

    // Ten-coin select: anything in tens or hundreds is paid in tens first.
    function automatic logic want_ten(input logic [11:0] b);
        return (b[11:8] != 4'd0) || (b[7:4] != 4'd0);
    endfunction

    // BCD minus 10 with borrow from hundreds; ones untouched.
    function automatic logic [11:0] dec10(input logic [11:0] b);
        if (b[7:4] != 4'd0)
            return {b[11:8], b[7:4] - 4'd1, b[3:0]};
        else
            return {b[11:8] - 4'd1, 4'd9, b[3:0]};
    endfunction

    function automatic logic [11:0] dec5(input logic [11:0] b);
        return {b[11:4], b[3:0] - 4'd5};
    endfunction

    assign btn_rise = bus.cash_btn && !btn_q;

    // Two-flop synchronizer for the IR sensor (idle high) and request edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            btn_q   <= 1'b0;
        end else begin
            sync1_q <= bus.exit_sense;
            sync2_q <= sync1_q;
            btn_q   <= bus.cash_btn;
        end
    end

    // Next-state logic; eject lines are computed here so they are registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel10_d = sel10_q;
        retry_d = retry_q;
        rem_d   = rem_q;
        e10_d   = e10_q;
        e5_d    = e5_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        jam_d   = jam_q;
        case (state_q)
            S_IDLE: begin
                if (btn_rise && payable(bus.credit)) begin
                    rem_d   = bus.credit;
                    busy_d  = 1'b1;
                    sel10_d = want_ten(bus.credit);
                    e10_d   = want_ten(bus.credit);
                    e5_d    = !want_ten(bus.credit);
                    cnt_d   = '0;
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                if (cnt_q == PULSE_LAST) begin
                    e10_d   = 1'b0;
                    e5_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT_SENSE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT_SENSE: begin
                if (!sync2_q) begin
                    state_d = S_WAIT_CLEAR;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q) begin
                        busy_d  = 1'b0;
                        jam_d   = 1'b1;
                        state_d = S_JAM;
                    end else begin
                        // Second attempt with the same coin.
                        retry_d = 1'b1;
                        e10_d   = sel10_q;
                        e5_d    = !sel10_q;
                        cnt_d   = '0;
                        state_d = S_FIRE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT_CLEAR: begin
                if (sync2_q) begin
                    rem_d   = sel10_q ? dec10(rem_q) : dec5(rem_q);
                    retry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (payable(rem_q)) begin
                        sel10_d = want_ten(rem_q);
                        e10_d   = want_ten(rem_q);
                        e5_d    = !want_ten(rem_q);
                        state_d = S_FIRE;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_JAM: begin
                state_d = S_JAM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears eject drive without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel10_q <= 1'b0;
            retry_q <= 1'b0;
            rem_q   <= '0;
            e10_q   <= 1'b0;
            e5_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            jam_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel10_q <= sel10_d;
            retry_q <= retry_d;
            rem_q   <= rem_d;
            e10_q   <= e10_d;
            e5_q    <= e5_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            jam_q   <= jam_d;
        end
    end

    assign bus.eject10   = e10_q;
    assign bus.eject5    = e5_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.jam       = jam_q;
    assign bus.remaining = rem_q;
endmodule

// File: tb/tb_coin_payout.sv
// Randomized bench for coin_payout: a decimal-arithmetic model predicts the
// coin sequence and balance trail; a sensor responder confirms each coin.
module tb_coin_payout;
    localparam int PW = 4;
    localparam int TO = 20;
    localparam int GP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coin_payout_if bus();

    coin_payout #(.PULSE_W(PW), .TIMEOUT(TO), .GAP(GP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // mode 0: normal payout, 1: sensor never fires, 2: extra button edges while busy
    task automatic run_payout(input logic [11:0] cr, input int mode, input int dly, input int low_len);
        int val, n10, n5, ncoins, budget;
        bit pay;
        int exp_type[$];
        logic [11:0] exp_rem[$];
        logic [11:0] rem_before, prev_rem, final_exp;
        int coins, w, sens, ridx, done_cnt, tail, prev_type;
        bit overlap, finished, prev_on;

        val = from_bcd(cr);
        n10 = val / 10;
        n5  = ((val % 10) >= 5) ? 1 : 0;
        pay = (n10 > 0) || (n5 > 0);
        for (int i = 0; i < n10; i++) begin
            exp_type.push_back(10);
            val -= 10;
            exp_rem.push_back(to_bcd(val));
        end
        if (n5 > 0) begin
            exp_type.push_back(5);
            val -= 5;
            exp_rem.push_back(to_bcd(val));
        end
        if (mode == 1 && pay) begin
            prev_type = exp_type[0];
            exp_type.delete();
            exp_type.push_back(prev_type);
            exp_type.push_back(prev_type);
            exp_rem.delete();
        end
        ncoins = exp_type.size();
        budget = (ncoins + 1) * (PW + TO + dly + low_len + GP + 8) + 40;

        rem_before = bus.remaining;
        prev_rem   = rem_before;
        coins = 0; w = 0; sens = 0; ridx = 0; done_cnt = 0; tail = -1; prev_type = 0;
        overlap = 0; finished = 0; prev_on = 0;

        bus.credit     = cr;
        bus.exit_sense = 1'b1;
        bus.cash_btn   = 1'b0;
        @(negedge clk);
        bus.cash_btn   = 1'b1;

        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (mode == 2)
                bus.cash_btn = !(cyc == 6 || cyc == 10);
            if (cyc == 0) begin
                check_eq("req_busy", bus.busy, pay);
                check_eq("req_eject", {bus.eject10, bus.eject5},
                         pay ? ((exp_type[0] == 10) ? 2'b10 : 2'b01) : 2'b00);
                check_eq("req_rem", bus.remaining, pay ? cr : rem_before);
                prev_rem = bus.remaining;
            end else if (bus.remaining !== prev_rem) begin
                if (ridx < exp_rem.size())
                    check_eq($sformatf("rem_step%0d", ridx), bus.remaining, exp_rem[ridx]);
                else
                    check_eq("rem_unexpected", bus.remaining, prev_rem);
                ridx++;
                prev_rem = bus.remaining;
            end
            if (bus.eject10 && bus.eject5)
                overlap = 1;
            if (bus.eject10 || bus.eject5) begin
                w++;
                prev_type = bus.eject10 ? 10 : 5;
                prev_on   = 1;
            end else if (prev_on) begin
                prev_on = 0;
                if (coins < ncoins)
                    check_eq($sformatf("coin%0d_type", coins), prev_type, exp_type[coins]);
                else
                    check_eq("coin_excess", coins + 1, ncoins);
                check_eq($sformatf("coin%0d_width", coins), w, PW);
                coins++;
                w = 0;
                if (mode != 1)
                    sens = dly + low_len;
            end
            if (sens > 0) begin
                bus.exit_sense = (sens <= low_len) ? 1'b0 : 1'b1;
                sens--;
            end else begin
                bus.exit_sense = 1'b1;
            end
            if (bus.done) begin
                done_cnt++;
                check_eq("done_busy", bus.busy, 0);
            end
            if (tail < 0 && (bus.done || bus.jam || (!pay && cyc >= 12)))
                tail = 8;
            if (tail > 0)
                tail--;
            if (tail == 0) begin
                finished = 1;
                break;
            end
        end

        check_eq("finished", finished, 1);
        check_eq("coin_count", coins, ncoins);
        check_eq("done_count", done_cnt, (pay && mode != 1) ? 1 : 0);
        check_eq("jam", bus.jam, (pay && mode == 1) ? 1 : 0);
        check_eq("busy_end", bus.busy, 0);
        check_eq("eject_overlap", overlap, 0);
        if (!pay)
            final_exp = rem_before;
        else if (mode == 1)
            final_exp = cr;
        else
            final_exp = exp_rem[exp_rem.size() - 1];
        check_eq("final_rem", bus.remaining, final_exp);
        check_eq("rem_steps", ridx, exp_rem.size());
        $display("payout credit=%03h mode=%0d coins=%0d done=%0d jam=%0b remaining=%03h",
                 cr, mode, coins, done_cnt, bus.jam, bus.remaining);
    endtask

    initial begin
        int activity;
        bus.cash_btn   = 1'b0;
        bus.credit     = 12'h000;
        bus.exit_sense = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_eject10", bus.eject10, 0);
        check_eq("rst_eject5", bus.eject5, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_jam", bus.jam, 0);
        check_eq("rst_rem", bus.remaining, 12'h000);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_payout(12'h025, 0, 1, 4);
        run_payout(12'h100, 0, 1, 4);
        run_payout(12'h000, 0, 1, 4);
        run_payout(12'h003, 0, 1, 4);

        // Sensor dead: retry once then jam; a further request is ignored
        run_payout(12'h030, 1, 0, 0);
        bus.cash_btn = 1'b0;
        @(negedge clk);
        bus.cash_btn = 1'b1;
        activity = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.busy || bus.eject10 || bus.eject5 || bus.done)
                activity++;
        end
        check_eq("jam_ignore_edge", activity, 0);
        check_eq("jam_sticky", bus.jam, 1);
        check_eq("jam_rem_frozen", bus.remaining, 12'h030);
        $display("jam hold: activity=%0d jam=%0b", activity, bus.jam);
        rst = 1'b1;
        #1;
        check_eq("jam_rst_clear", bus.jam, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of an eject pulse
        bus.cash_btn = 1'b0;
        bus.credit   = 12'h020;
        @(negedge clk);
        bus.cash_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_eject10", bus.eject10, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_eject10", bus.eject10, 0);
        check_eq("async_busy", bus.busy, 0);
        check_eq("async_rem", bus.remaining, 12'h000);
        check_eq("async_jam", bus.jam, 0);
        $display("reset mid-fire: eject10=%0b busy=%0b remaining=%03h", bus.eject10, bus.busy, bus.remaining);
        @(negedge clk);
        rst = 1'b0;
        run_payout(12'h020, 0, 2, 2);

        // Held button with extra edges while busy
        run_payout(12'h010, 2, 2, 3);

        // Randomized credits and sensor timing
        for (int r = 0; r < 8; r++) begin
            logic [11:0] cr;
            cr = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            run_payout(cr, 0, int'($urandom_range(1, 4)), int'($urandom_range(1, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/coin_payout.md
# coin_payout

Coin payout controller for the slot machine. It is the dispensing counterpart of the IR coin acceptor. On a cash-out request it latches the 3-digit BCD credit and ejects 10-unit coins first, then at most one 5-unit coin. Each coin is confirmed by an active-low IR exit sensor, and the remaining BCD balance is decremented per confirmed coin. The block sits between the credit register and the hopper solenoid drivers and reports completion or jam to the game controller.

## Interface
- PULSE_W, 5_000_000: solenoid on-time in clk cycles (50 ms at 100 MHz).
- TIMEOUT, 50_000_000: max cycles from solenoid release to sensor-low before the attempt fails.
- GAP, 10_000_000: idle cycles after each confirmed coin.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- cash_btn  input  1  cash-out request, level; rising edge acts.
- credit  input  12  BCD credit [11:8] hundreds, [7:4] tens, [3:0] ones; sampled at request.
- exit_sense  input  1  IR exit sensor, active-low (low while a coin passes); asynchronous to clk.
- eject10  output  1  10-coin solenoid drive.
- eject5  output  1  5-coin solenoid drive.
- busy  output  1  payout in progress.
- done  output  1  one-cycle pulse on successful completion.
- jam  output  1  sticky jam flag, cleared only by rst.
- remaining  output  12  BCD balance still owed.

## Operation
- States: IDLE, FIRE, WAIT_SENSE, WAIT_CLEAR, GAP, DONE, JAM.
- Reset values (async, immediate): state IDLE, eject10=0, eject5=0, busy=0, done=0, jam=0, remaining=0x000, retry=0, sensor sync flops=1.
- exit_sense passes through a 2-flop synchronizer. All sensor decisions use the synchronized value.
- Payable means hundreds!=0, or tens!=0, or ones>=5.
- Coin select: if hundreds!=0 or tens!=0, select the 10-coin. Otherwise select the 5-coin. The select is held for the whole attempt.
- IDLE: on a cash_btn rising edge with credit payable:
  - remaining<=credit, busy<=1, go to FIRE.
  - A rising edge with credit not payable is ignored, with no busy and no done.
- FIRE: drive the selected eject line high for exactly PULSE_W cycles, then go to WAIT_SENSE with the timeout counter cleared.
- WAIT_SENSE:
  - Synced sensor low: go to WAIT_CLEAR.
  - Timeout counter reaches TIMEOUT with retry=0: set retry=1 and go to FIRE with the same coin.
  - Timeout with retry=1: go to JAM.
- WAIT_CLEAR: when the synced sensor returns high, decrement remaining, clear retry, go to GAP. No timeout applies in this state.
- Decrement of 10: if tens!=0, tens-1. Otherwise hundreds-1 and tens=9. Ones are unchanged.
- Decrement of 5: ones-5.
- GAP: after GAP cycles, go to FIRE with a new selection if remaining is still payable, else go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A residual ones value of 1–4 stays on remaining.
- JAM: eject lines low, busy=0, jam=1, remaining frozen. The block stays in JAM until rst.
- cash_btn is ignored in every state except IDLE. Holding it through completion does not retrigger; a fresh rising edge is required.
- Changes on credit while busy are ignored.
- Digit values above 9 on credit are outside the contract.

## Timing
- Request edge: cash_btn is sampled low at edge k-1 and high at edge k. At edge k the state becomes FIRE, busy=1, and the eject line goes high.
- Eject pulse width is exactly PULSE_W cycles. eject10 and eject5 are never high together.
- Sensor latency: remaining updates 3 edges after exit_sense rises (2 synchronizer stages plus 1 state register).
- Per-coin cycle count: PULSE_W + sensor wait + clear wait + GAP + 1.
- done is asserted in the cycle after the last GAP cycle. busy falls on that same edge.
- Reset asserted mid-pulse drops eject immediately, with no clock needed.

## Test plan
- credit=0x025, sensor pulsed low for 4 cycles after each eject (PULSE_W=4, TIMEOUT=20, GAP=3):
  - response is eject10, eject10, eject5;
  - remaining 0x015→0x005→0x000;
  - one done pulse; jam=0.
- credit=0x100, one coin: eject10 and remaining=0x090 (borrow). Full run gives 10 eject10 pulses and done.
- credit=0x000 or 0x003 with a cash_btn edge: busy stays 0, no eject, no done, remaining unchanged.
- Sensor held high: two eject10 pulses, then jam=1, busy=0, remaining=credit. A further cash_btn edge is ignored until rst.
- rst asserted mid-FIRE: eject10 drops asynchronously and all outputs return to reset values. The next request after release pays the full credit.
- cash_btn held high through a 0x010 payout, plus extra edges during busy: exactly one eject10, one done, and no second payout.
